// File: rtl/data_path.sv
// -----------------------------------------------------------------------------
// data_path
//
// 8-bit CPU datapath sitting directly under the control unit. Holds the
// instruction register, memory address register, program counter, the A and B
// accumulators and the condition code register. Two internal buses feed the
// registers and the ALU; all sequencing is done by the control unit, this
// block only routes and stores.
//
// Ports
//   Clk          in   clock, all state updates on the rising edge
//   Reset        in   synchronous active-high reset, clears every register
//   IR_Load      in   IR  <= Bus2
//   MAR_Load     in   MAR <= Bus2
//   PC_Load      in   PC  <= Bus2 (wins over PC_Inc)
//   PC_Inc       in   PC  <= PC + 1 (wraps)
//   A_Load       in   A   <= Bus2
//   B_Load       in   B   <= Bus2
//   CCR_Load     in   CCR <= flags of the current ALU result
//   ALU_Sel      in   [2:0] ALU opcode
//   Bus1_Sel     in   [1:0] 00 PC, 01 A, 10 B, 11 zero
//   Bus2_Sel     in   [1:0] 00 ALU result, 01 Bus1, 10 from_memory, 11 zero
//   from_memory  in   [7:0] memory read data
//   address      out  [7:0] MAR
//   to_memory    out  [7:0] Bus1 (combinational)
//   IR           out  [7:0] instruction register
//   CCR_Result   out  [3:0] {V,N,Z,C}
// -----------------------------------------------------------------------------
module data_path (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       IR_Load,
  input  logic       MAR_Load,
  input  logic       PC_Load,
  input  logic       PC_Inc,
  input  logic       A_Load,
  input  logic       B_Load,
  input  logic       CCR_Load,
  input  logic [2:0] ALU_Sel,
  input  logic [1:0] Bus1_Sel,
  input  logic [1:0] Bus2_Sel,
  input  logic [7:0] from_memory,
  output logic [7:0] address,
  output logic [7:0] to_memory,
  output logic [7:0] IR,
  output logic [3:0] CCR_Result
);

  // ALU opcodes
  localparam logic [2:0] OP_XOR = 3'b000;
  localparam logic [2:0] OP_NOT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_DEC = 3'b111;

  logic [7:0] ir_q,  ir_d;
  logic [7:0] mar_q, mar_d;
  logic [7:0] pc_q,  pc_d;
  logic [7:0] a_q,   a_d;
  logic [7:0] b_q,   b_d;
  logic [3:0] ccr_q, ccr_d;

  logic [7:0] bus1;
  logic [7:0] bus2;

  logic [7:0] alu_y;      // effective second operand (B, or 1 for inc/dec)
  logic [8:0] alu_r;      // bit 8 carries carry-out / borrow
  logic [7:0] alu_result;
  logic       flag_v;
  logic       flag_c;
  logic       flag_n;
  logic       flag_z;

  // ---------------------------------------------------------------------------
  // Buses
  // ---------------------------------------------------------------------------
  always_comb begin
    bus1 = 8'h00;
    unique case (Bus1_Sel)
      2'b00:   bus1 = pc_q;
      2'b01:   bus1 = a_q;
      2'b10:   bus1 = b_q;
      default: bus1 = 8'h00;
    endcase
  end

  always_comb begin
    bus2 = 8'h00;
    unique case (Bus2_Sel)
      2'b00:   bus2 = alu_result;
      2'b01:   bus2 = bus1;
      2'b10:   bus2 = from_memory;
      default: bus2 = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU: X = Bus1, Y = B (or the constant 1 for increment/decrement)
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_y  = ((ALU_Sel == OP_INC) || (ALU_Sel == OP_DEC)) ? 8'h01 : b_q;
    alu_r  = 9'h000;
    flag_v = 1'b0;
    flag_c = 1'b0;
    unique case (ALU_Sel)
      OP_XOR:  alu_r = {1'b0, bus1 ^ alu_y};
      OP_NOT:  alu_r = {1'b0, ~bus1};
      OP_AND:  alu_r = {1'b0, bus1 & alu_y};
      OP_OR:   alu_r = {1'b0, bus1 | alu_y};
      OP_ADD, OP_INC: begin
        alu_r  = {1'b0, bus1} + {1'b0, alu_y};
        flag_c = alu_r[8];
        flag_v = (bus1[7] == alu_y[7]) && (alu_r[7] != bus1[7]);
      end
      default: begin // OP_SUB, OP_DEC
        // 9-bit subtraction: bit 8 is set exactly when X < Y' unsigned.
        alu_r  = {1'b0, bus1} - {1'b0, alu_y};
        flag_c = alu_r[8];
        flag_v = (bus1[7] != alu_y[7]) && (alu_r[7] != bus1[7]);
      end
    endcase
    alu_result = alu_r[7:0];
    flag_n     = alu_r[7];
    flag_z     = (alu_r[7:0] == 8'h00);
  end

  // ---------------------------------------------------------------------------
  // Next-state for the register file
  // ---------------------------------------------------------------------------
  always_comb begin
    ir_d  = IR_Load  ? bus2 : ir_q;
    mar_d = MAR_Load ? bus2 : mar_q;
    a_d   = A_Load   ? bus2 : a_q;
    b_d   = B_Load   ? bus2 : b_q;
    ccr_d = CCR_Load ? {flag_v, flag_n, flag_z, flag_c} : ccr_q;
    // A direct load beats increment so jumps are never off by one.
    if (PC_Load) begin
      pc_d = bus2;
    end else if (PC_Inc) begin
      pc_d = pc_q + 8'd1;
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ir_q  <= 8'h00;
      mar_q <= 8'h00;
      pc_q  <= 8'h00;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      ccr_q <= 4'h0;
    end else begin
      ir_q  <= ir_d;
      mar_q <= mar_d;
      pc_q  <= pc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      ccr_q <= ccr_d;
    end
  end

  assign address    = mar_q;
  assign to_memory  = bus1;
  assign IR         = ir_q;
  assign CCR_Result = ccr_q;

endmodule

// File: tb/tb_data_path.sv
// -----------------------------------------------------------------------------
// tb_data_path
//
// Directed bench for data_path. Internal registers are observed through the
// to_memory output by steering Bus1_Sel (00 PC, 01 A, 10 B); IR, MAR and CCR
// are read from their own outputs. Inputs change 1 ns after the rising edge,
// outputs are sampled in the same quiet window.
// -----------------------------------------------------------------------------
module tb_data_path;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc;
  logic       A_Load, B_Load, CCR_Load;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic [7:0] from_memory;
  logic [7:0] address, to_memory, IR;
  logic [3:0] CCR_Result;

  int checks = 0;
  int errors = 0;

  data_path dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .IR_Load     (IR_Load),
    .MAR_Load    (MAR_Load),
    .PC_Load     (PC_Load),
    .PC_Inc      (PC_Inc),
    .A_Load      (A_Load),
    .B_Load      (B_Load),
    .CCR_Load    (CCR_Load),
    .ALU_Sel     (ALU_Sel),
    .Bus1_Sel    (Bus1_Sel),
    .Bus2_Sel    (Bus2_Sel),
    .from_memory (from_memory),
    .address     (address),
    .to_memory   (to_memory),
    .IR          (IR),
    .CCR_Result  (CCR_Result)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end else begin
      $display("ok   %s: %02h", tag, obs);
    end
  endtask

  task automatic idle();
    Reset    = 1'b0;
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    A_Load   = 1'b0;
    B_Load   = 1'b0;
    CCR_Load = 1'b0;
    ALU_Sel  = 3'b000;
    Bus1_Sel = 2'b00;
    Bus2_Sel = 2'b00;
  endtask

  // Apply whatever is currently driven across one rising edge, then drop strobes.
  task automatic step();
    @(posedge Clk);
    #1;
    idle();
  endtask

  // Peek a register through Bus1 / to_memory.
  task automatic peek(input logic [1:0] sel, output logic [7:0] v);
    Bus1_Sel = sel;
    #1;
    v = to_memory;
  endtask

  task automatic load_a(input logic [7:0] v);
    from_memory = v; Bus2_Sel = 2'b10; A_Load = 1'b1; step();
  endtask

  task automatic load_b(input logic [7:0] v);
    from_memory = v; Bus2_Sel = 2'b10; B_Load = 1'b1; step();
  endtask

  task automatic load_pc(input logic [7:0] v);
    from_memory = v; Bus2_Sel = 2'b10; PC_Load = 1'b1; step();
  endtask

  // ALU vectors: op, A, B, expected A, expected {V,N,Z,C}
  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] ccr;
    string      name;
  } alu_vec_t;

  alu_vec_t alu_tbl[12] = '{
    '{3'b010, 8'h7F, 8'h01, 8'h80, 4'b1100, "add_7f_01"},
    '{3'b010, 8'hFF, 8'h01, 8'h00, 4'b0011, "add_ff_01"},
    '{3'b011, 8'h00, 8'h01, 8'hFF, 4'b0101, "sub_00_01"},
    '{3'b011, 8'h80, 8'h01, 8'h7F, 4'b1000, "sub_80_01"},
    '{3'b000, 8'hF0, 8'h3C, 8'hCC, 4'b0100, "xor"},
    '{3'b001, 8'h0F, 8'h00, 8'hF0, 4'b0100, "not"},
    '{3'b100, 8'hF0, 8'h0F, 8'h00, 4'b0010, "and"},
    '{3'b101, 8'hF0, 8'h0F, 8'hFF, 4'b0100, "or"},
    '{3'b110, 8'h7F, 8'h55, 8'h80, 4'b1100, "inc_7f"},
    '{3'b110, 8'hFF, 8'h55, 8'h00, 4'b0011, "inc_ff"},
    '{3'b111, 8'h00, 8'h55, 8'hFF, 4'b0101, "dec_00"},
    '{3'b111, 8'h80, 8'h55, 8'h7F, 4'b1000, "dec_80"}
  };

  initial begin
    logic [7:0] v;
    idle();
    from_memory = 8'h00;

    // Initial clean state
    Reset = 1'b1; step();

    // ---- 1: reset with every strobe high ----
    load_a(8'h55);
    load_pc(8'h10);
    peek(2'b01, v); check("pre_rst_A", v, 8'h55);
    peek(2'b00, v); check("pre_rst_PC", v, 8'h10);
    from_memory = 8'hFF; Bus2_Sel = 2'b10;
    IR_Load = 1'b1; MAR_Load = 1'b1; PC_Load = 1'b1; PC_Inc = 1'b1;
    A_Load = 1'b1; B_Load = 1'b1; CCR_Load = 1'b1; ALU_Sel = 3'b010;
    Reset = 1'b1;
    step();
    peek(2'b00, v); check("rst_PC", v, 8'h00);
    peek(2'b01, v); check("rst_A", v, 8'h00);
    peek(2'b10, v); check("rst_B", v, 8'h00);
    peek(2'b11, v); check("bus1_sel11", v, 8'h00);
    check("rst_address", address, 8'h00);
    check("rst_IR", IR, 8'h00);
    check("rst_CCR", {4'h0, CCR_Result}, 8'h00);

    // ---- 2: fetch ----
    from_memory = 8'hA7;
    Bus1_Sel = 2'b00; Bus2_Sel = 2'b01; MAR_Load = 1'b1; step();
    check("fetch_MAR", address, 8'h00);
    PC_Inc = 1'b1; step();
    peek(2'b00, v); check("fetch_PC", v, 8'h01);
    from_memory = 8'hA7; Bus2_Sel = 2'b10; IR_Load = 1'b1; step();
    check("fetch_IR", IR, 8'hA7);
    Bus1_Sel = 2'b00; Bus2_Sel = 2'b01; MAR_Load = 1'b1; step();
    check("fetch_MAR_pc1", address, 8'h01);

    // ---- 3/4: ALU operations into A with CCR update ----
    foreach (alu_tbl[i]) begin
      load_a(alu_tbl[i].a);
      load_b(alu_tbl[i].b);
      Bus1_Sel = 2'b01; Bus2_Sel = 2'b00; ALU_Sel = alu_tbl[i].op;
      A_Load = 1'b1; CCR_Load = 1'b1;
      step();
      peek(2'b01, v); check({alu_tbl[i].name, "_A"}, v, alu_tbl[i].r);
      check({alu_tbl[i].name, "_CCR"}, {4'h0, CCR_Result}, {4'h0, alu_tbl[i].ccr});
    end

    // CCR holds without CCR_Load (last op left 4'b1000)
    load_a(8'hFF); load_b(8'h01);
    Bus1_Sel = 2'b01; Bus2_Sel = 2'b00; ALU_Sel = 3'b010; A_Load = 1'b1; step();
    peek(2'b01, v); check("nocc_A", v, 8'h00);
    check("nocc_CCR_hold", {4'h0, CCR_Result}, 8'h08);

    // Shared Bus2 value on simultaneous loads
    from_memory = 8'h96; Bus2_Sel = 2'b10;
    A_Load = 1'b1; B_Load = 1'b1; IR_Load = 1'b1; step();
    peek(2'b01, v); check("multi_A", v, 8'h96);
    peek(2'b10, v); check("multi_B", v, 8'h96);
    check("multi_IR", IR, 8'h96);

    // Bus2_Sel=11 drives zero
    Bus2_Sel = 2'b11; A_Load = 1'b1; step();
    peek(2'b01, v); check("bus2_sel11_A", v, 8'h00);

    // ---- 5: PC corners ----
    load_pc(8'hFF);
    PC_Inc = 1'b1; step();
    peek(2'b00, v); check("pc_wrap", v, 8'h00);
    from_memory = 8'h3C; Bus2_Sel = 2'b10; PC_Load = 1'b1; PC_Inc = 1'b1; step();
    peek(2'b00, v); check("pc_load_prio", v, 8'h3C);
    step();
    peek(2'b00, v); check("pc_hold", v, 8'h3C);

    // ---- 6: reset in the middle of an ADD ----
    load_a(8'h7F); load_b(8'h01);
    Reset = 1'b1; Bus1_Sel = 2'b01; Bus2_Sel = 2'b00; ALU_Sel = 3'b010;
    A_Load = 1'b1; CCR_Load = 1'b1; step();
    peek(2'b01, v); check("midrst_A", v, 8'h00);
    check("midrst_CCR", {4'h0, CCR_Result}, 8'h00);
    // B was cleared too, so 0 + 0 = 0 with Z set
    Bus1_Sel = 2'b01; Bus2_Sel = 2'b00; ALU_Sel = 3'b010;
    A_Load = 1'b1; CCR_Load = 1'b1; step();
    peek(2'b01, v); check("postrst_A", v, 8'h00);
    check("postrst_CCR", {4'h0, CCR_Result}, 8'h02);
    // And a real add after reloading B
    load_b(8'h21);
    Bus1_Sel = 2'b01; Bus2_Sel = 2'b00; ALU_Sel = 3'b010;
    A_Load = 1'b1; CCR_Load = 1'b1; step();
    peek(2'b01, v); check("postrst_add_A", v, 8'h21);
    check("postrst_add_CCR", {4'h0, CCR_Result}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
